event_pulse_scheduler: RTL and testbench
========================================

EVENT_PULSE_SCHEDULER -- requirements
Module: event_pulse_scheduler

Interface
REQ-001 Parameter N_EVENTS, default 4, number of event channels (2..16).
REQ-002 Parameter ID_W, default 2, width of channel index, SHALL equal clog2(N_EVENTS).
REQ-003 clk_i  input  1  single clock; all logic rising-edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 event_i  input  N_EVENTS  level event sources; a rising edge on each bit is one event.
REQ-006 mask_i  input  N_EVENTS  1 = channel enabled; 0 = new edges ignored, existing pending bit kept but not granted.
REQ-007 grant_valid_o  output  1  a granted event is offered to the consumer.
REQ-008 grant_id_o  output  ID_W  index of the offered channel, stable while grant_valid_o=1.
REQ-009 grant_ready_i  input  1  consumer accepts; handshake = grant_valid_o & grant_ready_i.
REQ-010 pending_o  output  N_EVENTS  current pending register.
REQ-011 overflow_o  output  N_EVENTS  sticky per-channel lost-event flags.
REQ-012 overflow_clr_i  input  N_EVENTS  1-cycle write-1-to-clear for overflow_o bits.

Function
REQ-013 Each channel SHALL detect rising edges with a 2-flop register pair: pulse = reg1 & ~reg2, where reg1 samples event_i at every edge.
REQ-014 Edge latency: event_i high before edge E0 -> pulse high in cycle E0..E1 -> pending bit set at E1.
REQ-015 Pulse on a masked channel SHALL be discarded (no pending, no overflow).
REQ-016 Pulse on an unmasked channel whose pending bit is already 1 and is not being handshaken that cycle SHALL set overflow_o for that channel and leave pending=1.
REQ-017 Pulse on a channel in the same cycle as its handshake SHALL leave pending=1 with no overflow (new event queued).
REQ-018 FSM SHALL have two states: IDLE (grant_valid_o=0) and OFFER (grant_valid_o=1).
REQ-019 IDLE -> OFFER at an edge where (pending & mask) != 0; grant_id_o loaded at that edge by round-robin selection; first valid edge is E2 for REQ-014 timing.
REQ-020 Round-robin: search starts at (last_granted_id + 1) mod N_EVENTS, ascending with wrap; lowest index at or after start wins.
REQ-021 OFFER holds grant_id_o and grant_valid_o until handshake; an offered grant SHALL NOT be withdrawn, even if mask_i for it drops.
REQ-022 On handshake: pending[grant_id_o] cleared (subject to REQ-017), last_granted_id := grant_id_o, FSM -> IDLE; minimum one IDLE cycle between grants (max throughput one event per 2 cycles).
REQ-023 overflow_clr_i bit clears its overflow_o bit; simultaneous set (REQ-016) and clear SHALL leave the bit set.
REQ-024 pending_o and overflow_o SHALL be direct register outputs (no combinational path from inputs).

Reset
REQ-025 While rst_i=1 at an edge: edge flops, pending, overflow, grant_valid_o, grant_id_o cleared to 0, FSM -> IDLE, last_granted_id := N_EVENTS-1 (so channel 0 wins first).
REQ-026 Reset mid-OFFER SHALL drop grant_valid_o at the next edge with no handshake; event_i held high through reset SHALL produce one event after reset release.

Structure
REQ-027 FSM state encoding and the default N_EVENTS/ID_W constants SHALL live in the shared package used by the UDP/IP control blocks.
REQ-028 Per-channel edge detection SHALL be the existing pulse_on_posedge module, one instance per channel via generate; arbitration and FSM stay in this module.

Verification
REQ-029 Reset, then event_i=4'b0001 held, grant_ready_i=1 -> grant_valid_o=1 with id 0 exactly at the 3rd edge after event, one handshake only, pending_o returns 0.
REQ-030 event_i 4'b1111 rise together, grant_ready_i=1 -> grants in order 0,1,2,3, each valid for 1 cycle, separated by 1 idle cycle.
REQ-031 grant_ready_i=0 with id 2 offered, second rising edge on channel 2 -> overflow_o=4'b0100, pending_o[2]=1, grant_id_o stays 2; overflow_clr_i=4'b0100 -> overflow_o=0.
REQ-032 Channel 1 re-rises in the handshake cycle of id 1 -> pending_o[1]=1 afterwards, overflow_o[1]=0, next grant id 1 (only pending).
REQ-033 mask_i=4'b1101, edges on channels 1 and 3 -> only id 3 granted, pending_o[1]=0; rst_i pulsed during OFFER -> grant_valid_o=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/event_pulse_scheduler_pkg.sv
// event_pulse_scheduler_pkg: shared FSM encoding and default sizing for the event scheduler
package event_pulse_scheduler_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_t;

    localparam int N_EVENTS_DEF = 4;
    localparam int ID_W_DEF     = 2;

endpackage

// File: rtl/event_pulse_scheduler_pulse.sv
// pulse_on_posedge: one-cycle pulse on each rising edge of sig_i, two-flop detector
module pulse_on_posedge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic reg1, reg2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg1 <= 1'b0;
            reg2 <= 1'b0;
        end else begin
            reg1 <= sig_i;
            reg2 <= reg1;
        end
    end

    assign pulse_o = reg1 & ~reg2;

endmodule

// File: rtl/event_pulse_scheduler.sv
// event_pulse_scheduler: latches per-channel rising edges as pending events and offers them round-robin
module event_pulse_scheduler
    import event_pulse_scheduler_pkg::*;
#(
    parameter int N_EVENTS = N_EVENTS_DEF,
    parameter int ID_W     = ID_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_EVENTS-1:0] event_i,
    input  logic [N_EVENTS-1:0] mask_i,
    output logic                grant_valid_o,
    output logic [ID_W-1:0]     grant_id_o,
    input  logic                grant_ready_i,
    output logic [N_EVENTS-1:0] pending_o,
    output logic [N_EVENTS-1:0] overflow_o,
    input  logic [N_EVENTS-1:0] overflow_clr_i
);

    sched_state_t        state_q, state_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d, last_q, last_d, rr_id, idx;
    logic [N_EVENTS-1:0] pulse, hit, clr_vec, masked, pending_q, pending_d, overflow_q, overflow_d;
    logic                hs;

    for (genvar i = 0; i < N_EVENTS; i++) begin : g_edge
        pulse_on_posedge u_edge (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .sig_i  (event_i[i]),
            .pulse_o(pulse[i])
        );
    end

    assign hs     = (state_q == OFFER) & grant_ready_i;
    assign hit    = pulse & mask_i;
    assign masked = pending_q & mask_i;

    // A pulse landing in its own handshake cycle re-queues instead of overflowing
    always_comb begin
        clr_vec = '0;
        if (hs) clr_vec[grant_id_q] = 1'b1;
        pending_d  = hit | (pending_q & ~clr_vec);
        overflow_d = (overflow_q & ~overflow_clr_i) | (hit & pending_q & ~clr_vec);
    end

    // Descending scan so the lowest offset from last_q+1 is written last and wins
    always_comb begin
        rr_id = '0;
        idx   = '0;
        for (int k = N_EVENTS - 1; k >= 0; k--) begin
            idx = ID_W'((int'(last_q) + 1 + k) % N_EVENTS);
            if (masked[idx]) rr_id = idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        if (state_q == IDLE && |masked) begin
            state_d    = OFFER;
            grant_id_d = rr_id;
        end else if (hs) begin
            state_d = IDLE;
            last_d  = grant_id_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_q     <= ID_W'(N_EVENTS - 1);
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign grant_valid_o = (state_q == OFFER);
    assign grant_id_o    = grant_id_q;
    assign pending_o     = pending_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_event_pulse_scheduler.sv
// tb_event_pulse_scheduler: directed scenario checks for event_pulse_scheduler
module tb_event_pulse_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] event_i, mask_i, overflow_clr_i, pending_o, overflow_o;
    logic       grant_valid_o, grant_ready_i;
    logic [1:0] grant_id_o;
    int         passed = 0;
    int         total  = 0;

    event_pulse_scheduler dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .event_i       (event_i),
        .mask_i        (mask_i),
        .grant_valid_o (grant_valid_o),
        .grant_id_o    (grant_id_o),
        .grant_ready_i (grant_ready_i),
        .pending_o     (pending_o),
        .overflow_o    (overflow_o),
        .overflow_clr_i(overflow_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; event_i = '0; mask_i = 4'hF; grant_ready_i = 1'b0; overflow_clr_i = '0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (grant_valid_o !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", grant_valid_o); else passed++;
        total++; if (grant_id_o !== 2'd0) $display("FAIL reset_id got=%0d exp=0", grant_id_o); else passed++;
        total++; if (pending_o !== 4'h0) $display("FAIL reset_pending got=%b exp=0000", pending_o); else passed++;
        total++; if (overflow_o !== 4'h0) $display("FAIL reset_overflow got=%b exp=0000", overflow_o); else passed++;
    endtask

    task automatic test_single();
        int grants = 0;
        do_reset();
        grant_ready_i = 1'b1;
        event_i = 4'b0001;
        step();
        step();
        total++; if (pending_o !== 4'b0001 || grant_valid_o !== 1'b0) $display("FAIL single_e1 got pend=%b v=%0b exp pend=0001 v=0", pending_o, grant_valid_o); else passed++;
        step();
        total++; if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd0) $display("FAIL single_e2 got v=%0b id=%0d exp v=1 id=0", grant_valid_o, grant_id_o); else passed++;
        for (int c = 0; c < 6; c++) begin
            if (grant_valid_o) grants++;
            step();
        end
        total++; if (grants !== 1) $display("FAIL single_count got=%0d exp=1", grants); else passed++;
        total++; if (pending_o !== 4'h0) $display("FAIL single_pending got=%b exp=0000", pending_o); else passed++;
    endtask

    task automatic test_all_rr();
        logic [9:0] exp_v = 10'b0101010100;
        do_reset();
        grant_ready_i = 1'b1;
        event_i = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            step();
            total++; if (grant_valid_o !== exp_v[c]) $display("FAIL rr_valid c=%0d got=%0b exp=%0b", c, grant_valid_o, exp_v[c]); else passed++;
            if (exp_v[c]) begin
                total++; if (grant_id_o !== 2'((c - 2) / 2)) $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, grant_id_o, (c - 2) / 2); else passed++;
            end
        end
        total++; if (pending_o !== 4'h0) $display("FAIL rr_pending got=%b exp=0000", pending_o); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        event_i = 4'b0100;
        step();
        step();
        step();
        total++; if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd2) $display("FAIL ovf_offer got v=%0b id=%0d exp v=1 id=2", grant_valid_o, grant_id_o); else passed++;
        event_i = 4'b0000;
        step();
        event_i = 4'b0100;
        step();
        step();
        total++; if (overflow_o !== 4'b0100) $display("FAIL ovf_set got=%b exp=0100", overflow_o); else passed++;
        total++; if (pending_o[2] !== 1'b1) $display("FAIL ovf_pending got=%0b exp=1", pending_o[2]); else passed++;
        total++; if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd2) $display("FAIL ovf_hold got v=%0b id=%0d exp v=1 id=2", grant_valid_o, grant_id_o); else passed++;
        overflow_clr_i = 4'b0100;
        step();
        overflow_clr_i = 4'b0000;
        total++; if (overflow_o !== 4'h0) $display("FAIL ovf_clear got=%b exp=0000", overflow_o); else passed++;
        grant_ready_i = 1'b1;
        step();
        total++; if (grant_valid_o !== 1'b0 || pending_o !== 4'h0) $display("FAIL ovf_drain got v=%0b pend=%b exp v=0 pend=0000", grant_valid_o, pending_o); else passed++;
    endtask

    task automatic test_requeue();
        do_reset();
        event_i = 4'b0010;
        step();
        step();
        step();
        total++; if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd1) $display("FAIL rq_offer got v=%0b id=%0d exp v=1 id=1", grant_valid_o, grant_id_o); else passed++;
        event_i = 4'b0000;
        step();
        event_i = 4'b0010;
        step();
        grant_ready_i = 1'b1;
        step();
        total++; if (grant_valid_o !== 1'b0 || pending_o[1] !== 1'b1) $display("FAIL rq_hs got v=%0b pend=%b exp v=0 pend[1]=1", grant_valid_o, pending_o); else passed++;
        total++; if (overflow_o[1] !== 1'b0) $display("FAIL rq_overflow got=%b exp bit1=0", overflow_o); else passed++;
        step();
        total++; if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd1) $display("FAIL rq_regrant got v=%0b id=%0d exp v=1 id=1", grant_valid_o, grant_id_o); else passed++;
        step();
        total++; if (pending_o !== 4'h0) $display("FAIL rq_drain got=%b exp=0000", pending_o); else passed++;
    endtask

    task automatic test_mask_reset();
        do_reset();
        mask_i  = 4'b1101;
        event_i = 4'b1010;
        step();
        step();
        total++; if (pending_o !== 4'b1000) $display("FAIL mask_pending got=%b exp=1000", pending_o); else passed++;
        step();
        total++; if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd3) $display("FAIL mask_offer got v=%0b id=%0d exp v=1 id=3", grant_valid_o, grant_id_o); else passed++;
        mask_i = 4'b0000;
        step();
        total++; if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd3) $display("FAIL mask_nowithdraw got v=%0b id=%0d exp v=1 id=3", grant_valid_o, grant_id_o); else passed++;
        mask_i = 4'b1101;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++; if ({grant_valid_o, grant_id_o, pending_o, overflow_o} !== 11'd0) $display("FAIL mid_reset got v=%0b id=%0d pend=%b ovf=%b exp all 0", grant_valid_o, grant_id_o, pending_o, overflow_o); else passed++;
        step();
        step();
        total++; if (pending_o !== 4'b1000) $display("FAIL held_event got=%b exp=1000", pending_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rr();
        test_overflow();
        test_requeue();
        test_mask_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
